// File: rtl/mem_access_stage.sv
// Data-memory access stage sitting between EX/MEM and MEM/WB.
// Turns a load/store from EX/MEM into a req/ack transaction with a
// variable-latency data memory, freezes the upstream pipeline while the
// transaction is outstanding, and delivers the sized/extended load result.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_DATA     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] MEMdata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LAST_INT = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 32'd0);

  // Access size from funct3; the unused encodings 011/110/111 fall to word.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       memdata_q, memdata_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;

  logic        access_s;
  logic [1:0]  size_s;
  logic        misaligned_s;
  logic        start_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;

  // Decode the incoming access: size, alignment and whether it may start.
  always_comb begin
    access_s     = MemRead_i | MemWrite_i;
    size_s       = size_of(funct3_i);
    misaligned_s = 1'b0;
    case (size_s)
      SZ_H:    misaligned_s = addr_i[0];
      SZ_W:    misaligned_s = (addr_i[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    start_s    = (state_q == ST_IDLE) & access_s & ~misaligned_s;
    misalign_o = (state_q == ST_IDLE) & access_s & misaligned_s;
    stall_o    = start_s | (state_q == ST_REQ);
  end

  // Steer store data onto its byte lanes; loads always fetch the whole word.
  always_comb begin
    be_s = 4'b1111;
    wd_s = wdata_i;
    if (MemWrite_i) begin
      case (size_s)
        SZ_B: begin
          be_s = 4'b0001 << addr_i[1:0];
          wd_s = {4{wdata_i[7:0]}};
        end
        SZ_H: begin
          be_s = addr_i[1] ? 4'b1100 : 4'b0011;
          wd_s = {2{wdata_i[15:0]}};
        end
        default: begin
          be_s = 4'b1111;
          wd_s = wdata_i;
        end
      endcase
    end else begin
      be_s = 4'b1111;
      wd_s = wdata_i;
    end
  end

  // Next-state logic of the IDLE -> REQ -> DONE access sequencer.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    memdata_d   = memdata_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite_i;
          mem_addr_d  = {addr_i[31:2], 2'b00};
          mem_be_d    = be_s;
          mem_wdata_d = wd_s;
          cnt_d       = '0;
          lane_d      = addr_i[1:0];
          size_d      = size_s;
          uns_d       = funct3_i[2];
          state_d     = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we_q) begin
            memdata_d = load_extend(mem_rdata_i, size_q, uns_q, lane_q);
          end else begin
            memdata_d = memdata_q;
          end
          state_d = ST_DONE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          mem_req_d = 1'b0;
          memdata_d = RESET_DATA;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      memdata_q   <= RESET_DATA;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      lane_q      <= 2'b00;
      size_q      <= SZ_W;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      memdata_q   <= memdata_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign MEMdata_o   = memdata_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected completions are queued
// when an access is launched and popped when done_o/timeout_o appears.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] MEMdata_o;
  logic        done_o, misalign_o, timeout_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        to;
  } exp_t;
  exp_t sb_q[$];

  mem_access_stage #(.TIMEOUT_CYCLES(16), .RESET_DATA(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .MEMdata_o(MEMdata_o), .done_o(done_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Launch one access, answer it after ack_after REQ cycles (0 = never), check it.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_after,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_data, input logic exp_to,
                           input int exp_req);
    exp_t e;
    int   req_n;
    int   stall_n;
    bit   seen;
    e.data = exp_data;
    e.to   = exp_to;
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk_eq({tag, "_req_idle"}, mem_req_o, 32'd0);
    stall_n = int'(stall_o);
    req_n   = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk_i); #1;
      if (mem_req_o) begin
        req_n++;
        if (req_n == 1) begin
          chk_eq({tag, "_addr"}, mem_addr_o, exp_addr);
          chk_eq({tag, "_be"}, mem_be_o, exp_be);
          chk_eq({tag, "_we"}, mem_we_o, wr);
          if (wr) chk_eq({tag, "_wdata"}, mem_wdata_o, exp_wd);
        end
        mem_ack_i   = (ack_after != 0) && (req_n == ack_after);
        mem_rdata_i = rdata;
      end else if (done_o || timeout_o) begin
        seen = 1'b1;
        mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        if (sb_q.size() == 0) begin
          chk_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk_eq({tag, "_data"}, MEMdata_o, e.data);
          chk_eq({tag, "_timeout"}, timeout_o, e.to);
          chk_eq({tag, "_done"}, done_o, !e.to);
        end
      end else begin
        mem_ack_i = 1'b0;
      end
      @(negedge clk_i);
      if (!seen) stall_n += int'(stall_o);
      else chk_eq({tag, "_stall_done"}, stall_o, 32'd0);
    end
    chk_eq({tag, "_completed"}, seen, 32'd1);
    chk_eq({tag, "_req_cycles"}, req_n, exp_req);
    chk_eq({tag, "_stall_cycles"}, stall_n, exp_req + 1);
  endtask

  // Present a misaligned access and confirm nothing is issued.
  task automatic do_misalign(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp_data);
    @(posedge clk_i); #1;
    MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; addr_i = addr;
    @(negedge clk_i);
    chk_eq({tag, "_misalign"}, misalign_o, 32'd1);
    chk_eq({tag, "_stall"}, stall_o, 32'd0);
    @(posedge clk_i); #1;
    chk_eq({tag, "_req"}, mem_req_o, 32'd0);
    chk_eq({tag, "_data"}, MEMdata_o, exp_data);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_eq("rst_req", mem_req_o, 32'd0);
    chk_eq("rst_we", mem_we_o, 32'd0);
    chk_eq("rst_addr", mem_addr_o, 32'd0);
    chk_eq("rst_be", mem_be_o, 32'd0);
    chk_eq("rst_wdata", mem_wdata_o, 32'd0);
    chk_eq("rst_data", MEMdata_o, 32'd0);
    chk_eq("rst_done", done_o, 32'd0);
    chk_eq("rst_timeout", timeout_o, 32'd0);
    chk_eq("rst_stall", stall_o, 32'd0);
    rst_i = 1'b1;

    do_access("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hCAFE_BABE,
              32'h100, 4'b1111, 32'h0, 32'hCAFE_BABE, 1'b0, 3);

    // Reset during the second REQ cycle with ack present.
    @(posedge clk_i); #1;
    MemRead_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
    @(posedge clk_i); #1;
    chk_eq("rstreq_req1", mem_req_o, 32'd1);
    @(posedge clk_i); #1;
    chk_eq("rstreq_req2", mem_req_o, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344; rst_i = 1'b0; MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    chk_eq("rstreq_req", mem_req_o, 32'd0);
    chk_eq("rstreq_stall", stall_o, 32'd0);
    chk_eq("rstreq_data", MEMdata_o, 32'd0);
    chk_eq("rstreq_done", done_o, 32'd0);
    rst_i = 1'b1; mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    chk_eq("rstreq_done2", done_o, 32'd0);

    do_access("lb", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1, 32'h80FF_0000,
              32'h200, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0, 1);
    do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 2, 32'h80FF_0000,
              32'h200, 4'b1111, 32'h0, 32'h0000_0080, 1'b0, 2);
    do_access("lh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF_0000,
              32'h200, 4'b1111, 32'h0, 32'hFFFF_80FF, 1'b0, 1);
    do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1, 32'h80FF_0000,
              32'h200, 4'b1111, 32'h0, 32'h0000_80FF, 1'b0, 1);
    do_access("sb", 1'b0, 1'b1, 3'b000, 32'h101, 32'h1234_56AB, 1, 32'hFFFF_FFFF,
              32'h100, 4'b0010, 32'hABAB_ABAB, 32'h0000_80FF, 1'b0, 1);
    do_access("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 2, 32'hFFFF_FFFF,
              32'h100, 4'b1100, 32'hBEEF_BEEF, 32'h0000_80FF, 1'b0, 2);
    do_access("sw", 1'b0, 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF,
              32'h204, 4'b1111, 32'hDEAD_BEEF, 32'h0000_80FF, 1'b0, 1);
    do_access("rw_sb", 1'b1, 1'b1, 3'b000, 32'h200, 32'h0000_0077, 1, 32'h1234_5678,
              32'h200, 4'b0001, 32'h7777_7777, 32'h0000_80FF, 1'b0, 1);

    do_misalign("mis_lw", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0000_80FF);
    do_misalign("mis_sh", 1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_80FF);

    do_access("tmo", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'hFFFF_FFFF,
              32'h300, 4'b1111, 32'h0, 32'h0000_0000, 1'b1, 16);

    // A late ack while idle must not start or complete anything.
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      chk_eq("late_req", mem_req_o, 32'd0);
      chk_eq("late_done", done_o, 32'd0);
      chk_eq("late_data", MEMdata_o, 32'd0);
    end
    mem_ack_i = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
